// File: rtl/rv6_bus_pkg.sv
// Shared types for the rv6 data-bus arbiter: FSM states, write length codes
// and the hart-index width helper.
package rv6_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        LEN_B,
        LEN_H,
        LEN_W,
        LEN_D
    } len_e;

    // HART_IDX_W = clog2(N_HART), never narrower than one bit
    function automatic int hart_idx_w(input int n_hart);
        return (n_hart > 1) ? $clog2(n_hart) : 1;
    endfunction

endpackage

// File: rtl/rv6_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N (N need not be a power of two).
module rv6_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int unsigned   pos;
    logic [IW-1:0] pos_idx;

    // Scan from the farthest offset down so the offset closest to ptr_i wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = |req_i;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = int'(ptr_i) + (N - 1 - k);
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (req_i[pos_idx]) begin
                gnt_o          = '0;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/rv6_bus_arb.sv
// N-hart round-robin data-bus arbiter with AMO bus locking and
// write-invalidate broadcast to every hart except the writer.
module rv6_bus_arb
    import rv6_bus_pkg::*;
#(
    parameter int N_HART = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                     c_clk,
    input  logic                     c_rst,
    input  logic [N_HART*ADDR_W-1:0] h_addr,
    input  logic [N_HART-1:0]        h_ext,
    input  logic [N_HART-1:0]        h_rd,
    input  logic [N_HART-1:0]        h_wr,
    input  logic [N_HART*DATA_W-1:0] h_wdata,
    input  logic [N_HART*2-1:0]      h_len,
    output logic [LINE_W-1:0]        h_rdata,
    output logic [N_HART-1:0]        h_dv,
    input  logic [N_HART-1:0]        h_amo_req,
    output logic [N_HART-1:0]        h_amo_ack,
    output logic [N_HART-1:0]        h_inv,
    output logic [ADDR_W-1:0]        h_inv_addr,
    output logic [ADDR_W-1:0]        m_addr,
    output logic                     m_ext,
    output logic                     m_rd,
    output logic                     m_wr,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [1:0]               m_len,
    input  logic [LINE_W-1:0]        m_rdata,
    input  logic                     m_dv
);

    localparam int HART_IDX_W = hart_idx_w(N_HART);
    localparam logic [HART_IDX_W-1:0] LAST_HART = HART_IDX_W'(N_HART - 1);

    state_e                  state_q, state_d;
    logic [HART_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HART_IDX_W-1:0]   g_q, g_d;
    logic [HART_IDX_W-1:0]   lock_owner_q, lock_owner_d;
    logic                    lock_valid_q, lock_valid_d;
    logic                    is_wr_q, is_wr_d;
    logic                    m_rd_q, m_rd_d;
    logic                    m_wr_q, m_wr_d;
    logic                    m_ext_q, m_ext_d;
    logic [ADDR_W-1:0]       m_addr_q, m_addr_d;
    logic [DATA_W-1:0]       m_wdata_q, m_wdata_d;
    len_e                    m_len_q, m_len_d;
    logic [LINE_W-1:0]       h_rdata_q, h_rdata_d;
    logic [N_HART-1:0]       h_dv_q, h_dv_d;
    logic [N_HART-1:0]       h_inv_q, h_inv_d;

    logic [N_HART-1:0]       owner_oh, grant_oh, elig, pick_oh;
    logic [HART_IDX_W-1:0]   pick_idx;
    logic                    pick_valid, pick_wr, pick_amo;

    // While a lock is held only the owner's rd/wr may compete.
    always_comb begin
        owner_oh               = '0;
        owner_oh[lock_owner_q] = 1'b1;
        grant_oh               = '0;
        grant_oh[g_q]          = 1'b1;
        elig = lock_valid_q ? ((h_rd | h_wr) & owner_oh)
                            : (h_rd | h_wr | h_amo_req);
    end

    rv6_rr_pick #(
        .N  (N_HART),
        .IW (HART_IDX_W)
    ) u_pick (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign pick_wr  = |(pick_oh & h_wr);
    assign pick_amo = |(pick_oh & h_amo_req) & ~lock_valid_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        g_d          = g_q;
        is_wr_d      = is_wr_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        m_rd_d       = m_rd_q;
        m_wr_d       = m_wr_q;
        m_ext_d      = m_ext_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_len_d      = m_len_q;
        h_rdata_d    = h_rdata_q;
        h_dv_d       = '0;
        h_inv_d      = '0;

        if (lock_valid_q && !h_amo_req[lock_owner_q]) begin
            lock_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // A hart raising amo and rd/wr together takes the lock first.
                    if (pick_amo) begin
                        lock_valid_d = 1'b1;
                        lock_owner_d = pick_idx;
                    end else begin
                        state_d = BUSY;
                        g_d     = pick_idx;
                        is_wr_d = pick_wr;
                        m_rd_d  = ~pick_wr;
                        m_wr_d  = pick_wr;
                        for (int unsigned i = 0; i < N_HART; i++) begin
                            if (pick_oh[i]) begin
                                m_addr_d  = h_addr[i*ADDR_W +: ADDR_W];
                                m_ext_d   = h_ext[i];
                                m_wdata_d = h_wdata[i*DATA_W +: DATA_W];
                                m_len_d   = len_e'(h_len[i*2 +: 2]);
                            end
                        end
                    end
                end
            end
            BUSY: begin
                if (m_dv) begin
                    state_d   = DONE;
                    h_rdata_d = m_rdata;
                    m_rd_d    = 1'b0;
                    m_wr_d    = 1'b0;
                    h_dv_d    = grant_oh;
                    h_inv_d   = is_wr_q ? ~grant_oh : '0;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (g_q == LAST_HART) ? '0 : g_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            g_q          <= '0;
            is_wr_q      <= 1'b0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            m_rd_q       <= 1'b0;
            m_wr_q       <= 1'b0;
            m_ext_q      <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_len_q      <= LEN_B;
            h_rdata_q    <= '0;
            h_dv_q       <= '0;
            h_inv_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            g_q          <= g_d;
            is_wr_q      <= is_wr_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            m_rd_q       <= m_rd_d;
            m_wr_q       <= m_wr_d;
            m_ext_q      <= m_ext_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_len_q      <= m_len_d;
            h_rdata_q    <= h_rdata_d;
            h_dv_q       <= h_dv_d;
            h_inv_q      <= h_inv_d;
        end
    end

    assign h_rdata    = h_rdata_q;
    assign h_dv       = h_dv_q;
    assign h_inv      = h_inv_q;
    assign h_inv_addr = m_addr_q;
    assign h_amo_ack  = lock_valid_q ? owner_oh : '0;
    assign m_addr     = m_addr_q;
    assign m_ext      = m_ext_q;
    assign m_rd       = m_rd_q;
    assign m_wr       = m_wr_q;
    assign m_wdata    = m_wdata_q;
    assign m_len      = m_len_q;

endmodule

// File: doc/rv6_bus_arb.md
Name: rv6_bus_arb

Overview:
- N-hart data-bus arbiter for multi-core rv6 configurations.
- Sits between the per-core bus ports (c_addr/c_rd/c_wr/c_dv/c_amo_*) and one shared memory port.
- Multiplexes requests by round-robin and grants AMO bus locks (c_amo_req/c_amo_ack).
- Broadcasts write-invalidate (c_inv/c_inv_addr) to every hart except the writer.

Parameters:
N_HART, 4, number of cores; 2..8
LINE_W, 256, read line width in bits; equals CMEM_LINE
ADDR_W, 64, address width
DATA_W, 64, write data width

Ports:
c_clk  in  1  clock
c_rst  in  1  synchronous reset, active-high
h_addr  in  N_HART*ADDR_W  per-hart address, hart i at [i*ADDR_W +: ADDR_W]
h_ext  in  N_HART  per-hart external/uncached flag
h_rd  in  N_HART  per-hart read request, level
h_wr  in  N_HART  per-hart write request, level
h_wdata  in  N_HART*DATA_W  per-hart write data
h_len  in  N_HART*2  per-hart write length code
h_rdata  out  LINE_W  read data, shared by all harts
h_dv  out  N_HART  per-hart completion pulse
h_amo_req  in  N_HART  per-hart lock request, level
h_amo_ack  out  N_HART  lock granted
h_inv  out  N_HART  per-hart invalidate pulse
h_inv_addr  out  ADDR_W  invalidate address
m_addr  out  ADDR_W  memory address
m_ext  out  1  memory ext flag
m_rd  out  1  memory read
m_wr  out  1  memory write
m_wdata  out  DATA_W  memory write data
m_len  out  2  memory write length
m_rdata  in  LINE_W  memory read data
m_dv  in  1  memory completion, 1-cycle pulse

Behaviour:
- Clock and reset: single clock c_clk; reset c_rst is synchronous and active-high.
- Reset values:
  - all outputs 0: m_rd, m_wr, h_dv, h_amo_ack, h_inv, m_addr, h_rdata
  - state = IDLE, rr_ptr = 0, lock_valid = 0
- Reset during BUSY: m_rd/m_wr drop on the next edge; any later m_dv is ignored.
- Request rules:
  - A hart holds h_rd or h_wr high until it sees h_dv.
  - h_rd and h_wr both high on one hart is illegal; write takes priority.
- States:
  - IDLE -> BUSY: a request is eligible.
    - Eligible set = all requesters when no lock is held; only the lock owner when a lock is held.
    - Winner = first eligible index at or after rr_ptr, modulo N_HART.
    - On the edge, latch grant index g and the winner's addr/ext/wdata/len into the m_* registers.
    - Assert m_rd or m_wr from the next cycle. Request-to-m_rd latency is 1 cycle.
  - BUSY: hold all m_* outputs stable until m_dv.
  - BUSY -> DONE on m_dv:
    - Register m_rdata into h_rdata.
    - Drop m_rd/m_wr.
  - DONE, exactly 1 cycle:
    - h_dv[g] = 1.
    - For a write: h_inv[j] = 1 for every j != g, h_inv_addr = latched address.
    - rr_ptr <= (g+1) mod N_HART.
    - Then go to IDLE.
    - The hart deasserts its request in the DONE cycle, so IDLE never re-sees a stale request.
- Minimum spacing: back-to-back transactions take 3 cycles plus memory latency.
- AMO lock:
  - In IDLE with no lock held, h_amo_req is arbitrated with the same round-robin as rd/wr.
  - If an amo winner is chosen and the state is IDLE, set lock_valid and lock_owner, and assert h_amo_ack[owner] from the next cycle.
  - An amo grant does not enter BUSY.
  - While the lock is held, only lock_owner's rd/wr are granted; other harts stall indefinitely.
  - When h_amo_req[owner] falls, clear the lock and h_amo_ack next cycle.
  - Lock requests arriving during BUSY wait for IDLE.
- Same-cycle events:
  - An amo_req and a rd/wr from different harts compete purely by rr_ptr order.
  - The same hart raising amo_req and rd/wr gets the lock first.
- rr_ptr wraps from N_HART-1 to 0.
- Unused hart indices beyond N_HART do not exist; no wrap logic depends on a power of two.

Decomposition:
- Shared package rv6_bus_pkg:
  - state encoding (IDLE, BUSY, DONE)
  - len codes (B, H, W, D)
  - HART_IDX_W = clog2(N_HART)
- One sub-module: rv6_rr_pick.
  - Combinational round-robin priority picker: req vector + ptr -> one-hot grant + index.
  - Reused by the interrupt controller.

Test Plan:
- Single read, N_HART=4, hart2 reads 0x1000:
  - m_rd rises 1 cycle later with m_addr=0x1000.
  - m_dv after 5 cycles -> h_dv[2] pulses 1 cycle with h_rdata=m_rdata.
  - rr_ptr becomes 3.
- Fairness, all 4 harts hold h_rd continuously from reset:
  - Grant order 0,1,2,3,0.
  - No hart is granted twice before every other hart is served.
- Write invalidate, hart1 writes 0x2008 len=D, data 0xDEADBEEF:
  - m_wr with m_wdata=0xDEADBEEF.
  - DONE cycle: h_inv=4'b1101, h_inv_addr=0x2008, h_dv=4'b0010.
- AMO lock:
  - Hart3 raises amo_req -> h_amo_ack[3] next cycle.
  - Hart0 reads while lock held -> never granted.
  - Hart3 read and write complete.
  - Hart3 drops amo_req -> ack clears, and hart0 is granted within 2 cycles.
- Reset mid-transaction:
  - c_rst asserted in BUSY -> m_rd=0 next edge.
  - A late m_dv produces no h_dv.
  - The first post-reset grant goes to the lowest-index requester.
- Same-cycle contention, rr_ptr=2:
  - Hart1 raises amo_req, hart3 raises h_rd -> hart3 granted first; hart1 locked after hart3's DONE.
